calc_sequencer_2bit: RTL and testbench

Operand-entry sequencer for the 2-bit calculator datapath. It conditions the raw front-panel buttons (two-flop synchronise, debounce, rising-edge detect) and enforces the entry order A → B. It issues single-cycle `loadA`/`loadB` pulses to the operand registers and flags when the adder output reflects a complete operand pair. It replaces direct button-to-load wiring between the panel and the operand registers.

---
 rtl/calc_sequencer_2bit.sv | 138 +++++++++++++
 tb/tb_calc_sequencer_2bit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer_2bit.sv
// Operand-entry sequencer: conditions the raw front-panel buttons and enforces
// the A -> B load order, issuing one-cycle load/clear strobes to the datapath.
module calc_sequencer_2bit #(
  parameter int DB_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnLoadA,
  input  logic       btnLoadB,
  input  logic       btnClear,
  output logic       loadA,
  output logic       loadB,
  output logic       clr_pulse,
  output logic [1:0] state,
  output logic       result_valid,
  output logic       err
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_HAVE_A = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b10;

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TW-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  // Bit order for all per-button vectors: [2] clear, [1] B, [0] A.
  logic [2:0]     btn_raw;
  logic [2:0]     sync_1;
  logic [2:0]     sync_2;
  logic [2:0]     db_level;
  logic [2:0]     db_prev;
  logic [2:0]     press;
  logic [DBW-1:0] db_cnt [3];
  logic [TW-1:0]  to_cnt;
  logic           ev_clr;
  logic           ev_a;
  logic           ev_b;
  logic           timeout_hit;

  assign btn_raw = {btnClear, btnLoadB, btnLoadA};
  assign press   = db_level & ~db_prev;
  assign ev_clr  = press[2];
  assign ev_a    = press[1 - 1];
  assign ev_b    = press[1];

  // The counter sits one below the limit on the edge that would make it reach
  // TIMEOUT_CYCLES, so the abort lands exactly TIMEOUT_CYCLES cycles after entry.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1   <= '0;
      sync_2   <= '0;
      db_level <= '0;
      db_prev  <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_1  <= btn_raw;
      sync_2  <= sync_1;
      db_prev <= db_level;
      for (int i = 0; i < 3; i++) begin
        if (sync_2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync_2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only the highest-priority press is acted on; lower ones are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loadA        <= 1'b0;
      loadB        <= 1'b0;
      clr_pulse    <= 1'b0;
      state        <= ST_IDLE;
      result_valid <= 1'b0;
      err          <= 1'b0;
      to_cnt       <= '0;
    end else begin
      loadA     <= 1'b0;
      loadB     <= 1'b0;
      clr_pulse <= 1'b0;
      if (ev_clr) begin
        clr_pulse    <= 1'b1;
        err          <= 1'b0;
        result_valid <= 1'b0;
        state        <= ST_IDLE;
        to_cnt       <= '0;
      end else if (ev_a) begin
        loadA        <= 1'b1;
        result_valid <= 1'b0;
        state        <= ST_HAVE_A;
        to_cnt       <= '0;
      end else if (ev_b) begin
        case (state)
          ST_HAVE_A: begin
            loadB  <= 1'b1;
            state  <= ST_DONE;
            to_cnt <= '0;
          end
          ST_DONE: begin
            loadB        <= 1'b1;
            result_valid <= 1'b0;
          end
          default: err <= 1'b1;
        endcase
      end else begin
        case (state)
          ST_HAVE_A: begin
            if (timeout_hit) begin
              err    <= 1'b1;
              state  <= ST_IDLE;
              to_cnt <= '0;
            end else if (to_cnt != '1) begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          // Any load strobe has retired by now, so both registers hold the pair.
          ST_DONE: result_valid <= 1'b1;
          default: to_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer_2bit.sv
// Bench for calc_sequencer_2bit: directed scenarios followed by random button
// traffic, all checked against a behavioural model of the button/sequence rules.
module tb_calc_sequencer_2bit;

  localparam int DB = 4;
  localparam int TO = 16;

  localparam logic [1:0] M_IDLE   = 2'd0;
  localparam logic [1:0] M_HAVE_A = 2'd1;
  localparam logic [1:0] M_DONE   = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b0;
  logic       btn_c = 1'b0;
  logic       loadA;
  logic       loadB;
  logic       clr_pulse;
  logic [1:0] state;
  logic       result_valid;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_load_a = 0;
  int cnt_load_b = 0;
  int cnt_clr = 0;

  // Reference model: raw samples per edge since reset, debounced levels,
  // pending press events and the expected registered outputs.
  logic [2:0] raw_log [$];
  logic [2:0] m_level;
  logic [2:0] m_rose;
  logic [1:0] m_state;
  logic       m_err;
  logic       m_rv;
  logic       m_load_a;
  logic       m_load_b;
  logic       m_clr;
  int         edge_num;
  int         m_entered;

  calc_sequencer_2bit #(
    .DB_CYCLES(DB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btnLoadA(btn_a),
    .btnLoadB(btn_b),
    .btnClear(btn_c),
    .loadA(loadA),
    .loadB(loadB),
    .clr_pulse(clr_pulse),
    .state(state),
    .result_valid(result_valid),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, "/loadA"}, 32'(loadA), 32'(m_load_a));
    checkOutput({where, "/loadB"}, 32'(loadB), 32'(m_load_b));
    checkOutput({where, "/clr_pulse"}, 32'(clr_pulse), 32'(m_clr));
    checkOutput({where, "/state"}, 32'(state), 32'(m_state));
    checkOutput({where, "/result_valid"}, 32'(result_valid), 32'(m_rv));
    checkOutput({where, "/err"}, 32'(err), 32'(m_err));
  endtask

  task automatic modelReset();
    raw_log.delete();
    m_level   = '0;
    m_rose    = '0;
    m_state   = M_IDLE;
    m_err     = 1'b0;
    m_rv      = 1'b0;
    m_load_a  = 1'b0;
    m_load_b  = 1'b0;
    m_clr     = 1'b0;
    edge_num  = 0;
    m_entered = 0;
  endtask

  // One rising edge of the reference: act on presses seen in the previous
  // cycle, then decide from the last DB synchronised samples (raw input two
  // edges earlier) whether any debounced level flips on this edge.
  task automatic modelEdge();
    logic [2:0] ev;
    logic [2:0] rose_now;
    logic [2:0] entry;
    logic       differs;
    int         idx;
    if (rst) begin
      modelReset();
      return;
    end
    edge_num++;
    ev       = m_rose;
    m_load_a = 1'b0;
    m_load_b = 1'b0;
    m_clr    = 1'b0;
    if (ev[2]) begin
      m_clr   = 1'b1;
      m_err   = 1'b0;
      m_rv    = 1'b0;
      m_state = M_IDLE;
    end else if (ev[0]) begin
      m_load_a  = 1'b1;
      m_rv      = 1'b0;
      m_state   = M_HAVE_A;
      m_entered = edge_num;
    end else if (ev[1]) begin
      if (m_state == M_IDLE) begin
        m_err = 1'b1;
      end else if (m_state == M_HAVE_A) begin
        m_load_b = 1'b1;
        m_state  = M_DONE;
      end else begin
        m_load_b = 1'b1;
        m_rv     = 1'b0;
      end
    end else begin
      if (m_state == M_HAVE_A && TO != 0 && edge_num - m_entered == TO) begin
        m_err   = 1'b1;
        m_state = M_IDLE;
      end else if (m_state == M_DONE) begin
        m_rv = 1'b1;
      end
    end
    raw_log.push_back({btn_c, btn_b, btn_a});
    if (raw_log.size() > DB + 8) void'(raw_log.pop_front());
    rose_now = '0;
    for (int b = 0; b < 3; b++) begin
      differs = 1'b1;
      for (int j = 0; j < DB; j++) begin
        idx = raw_log.size() - 3 - j;
        entry = (idx >= 0) ? raw_log[idx] : 3'b000;
        if (entry[b] == m_level[b]) differs = 1'b0;
      end
      if (differs) begin
        rose_now[b] = ~m_level[b];
        m_level[b]  = ~m_level[b];
      end
    end
    m_rose = rose_now;
  endtask

  // One clock cycle: inputs change on the falling edge, outputs are compared
  // just after the rising edge.
  task automatic applyStimulus(input logic a, input logic b, input logic c,
                               input logic r);
    @(negedge clk);
    btn_a = a;
    btn_b = b;
    btn_c = c;
    rst   = r;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll("step");
    if (loadA === 1'b1) cnt_load_a++;
    if (loadB === 1'b1) cnt_load_b++;
    if (clr_pulse === 1'b1) cnt_clr++;
  endtask

  initial begin
    int   lat;
    bit   seen;
    logic pa;
    logic pb;
    logic pc;
    int   len;

    modelReset();
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_state", 32'(state), 32'd0);

    // A then B: strobe latency DB+3 edges, result_valid one cycle after loadB.
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (loadA === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    checkOutput("latency_loadA", lat, DB + 3);
    checkOutput("state_have_a", 32'(state), 32'd1);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (loadB === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    checkOutput("latency_loadB", lat, DB + 3);
    checkOutput("state_done", 32'(state), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("result_valid_after_loadB", 32'(result_valid), 32'd1);
    checkOutput("err_after_pair", 32'(err), 32'd0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Clear, then B from IDLE sets err; a further clear removes it.
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("state_after_clear", 32'(state), 32'd0);
    cnt_load_b = 0;
    repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("b_in_idle_no_load", cnt_load_b, 0);
    checkOutput("b_in_idle_err", 32'(err), 32'd1);
    cnt_clr = 0;
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("clear_one_pulse", cnt_clr, 1);
    checkOutput("clear_err", 32'(err), 32'd0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Short glitch is ignored; a long hold gives exactly one load.
    cnt_load_a = 0;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("glitch_no_load", cnt_load_a, 0);
    cnt_load_a = 0;
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_one_load", cnt_load_a, 1);

    // B and clear debounced together in HAVE_A: clear wins.
    cnt_clr    = 0;
    cnt_load_b = 0;
    repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("simul_clr_pulse", cnt_clr, 1);
    checkOutput("simul_no_loadB", cnt_load_b, 0);
    checkOutput("simul_state", 32'(state), 32'd0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout: IDLE again with err exactly TO cycles after entering HAVE_A.
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (loadA === 1'b1) seen = 1'b1;
    end
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (!seen && state === 2'd0) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    checkOutput("timeout_cycles", lat, TO);
    checkOutput("timeout_err", 32'(err), 32'd1);

    // Asynchronous reset while B is mid-debounce in HAVE_A.
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (loadA === 1'b1) seen = 1'b1;
    end
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkAll("async_reset");
    checkOutput("async_reset_state", 32'(state), 32'd0);
    checkOutput("async_reset_err", 32'(err), 32'd0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    cnt_load_b = 0;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (!seen && err === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    checkOutput("held_through_reset_latency", lat, DB + 3);
    checkOutput("held_through_reset_no_loadB", cnt_load_b, 0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Random button bursts of varying length, including glitches and idle gaps.
    for (int n = 0; n < 120; n++) begin
      pa  = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      pc  = ($urandom_range(0, 6) == 0);
      len = int'($urandom_range(1, 14));
      for (int k = 0; k < len; k++) applyStimulus(pa, pb, pc, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
